// File: rtl/demux16_1to4_buf.sv
// Registered 1-to-4 distributor for 16-bit words, with one-entry valid/ready holding slots per channel.
// Optional per-channel delivered-word counters are built when DEMUX16_CNT_EN is defined.
module demux16_1to4_buf #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      D_IN,
    input  logic [1:0]       SEL,
    input  logic             BCAST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [15:0]      D_OUT0,
    output logic [15:0]      D_OUT1,
    output logic [15:0]      D_OUT2,
    output logic [15:0]      D_OUT3,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2,
    output logic [CNT_W-1:0] CNT3
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NCH    = 4;

    logic [NCH-1:0][DATA_W-1:0] data_q;
    logic [NCH-1:0]             valid_q;
    logic [NCH-1:0]             free;
    logic [NCH-1:0]             target;
    logic [NCH-1:0]             load;
    logic [NCH-1:0]             deliver;
    logic                       accept;

    // A slot can take a word if it is empty or its consumer drains it this cycle.
    always_comb begin
        free     = ~valid_q | OUT_READY;
        target   = BCAST ? {NCH{1'b1}} : (NCH'(1) << SEL);
        IN_READY = !RST && (BCAST ? (&free) : free[SEL]);
        accept   = IN_VALID && IN_READY;
        load     = {NCH{accept}} & target;
        deliver  = valid_q & OUT_READY;
    end

    // Holding registers: reload wins over delivery so a channel sustains one word per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (load[n]) begin
                    data_q[n]  <= D_IN;
                    valid_q[n] <= 1'b1;
                end else if (deliver[n]) begin
                    valid_q[n] <= 1'b0;
                end
            end
        end
    end

    assign D_OUT0    = data_q[0];
    assign D_OUT1    = data_q[1];
    assign D_OUT2    = data_q[2];
    assign D_OUT3    = data_q[3];
    assign OUT_VALID = valid_q;

    logic [NCH-1:0][CNT_W-1:0] cnt_q;

`ifdef DEMUX16_CNT_EN
    // Delivered-word counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (deliver[n]) begin
                    cnt_q[n] <= cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign cnt_q = '0;
`endif

    assign CNT0 = cnt_q[0];
    assign CNT1 = cnt_q[1];
    assign CNT2 = cnt_q[2];
    assign CNT3 = cnt_q[3];

endmodule

// File: tb/tb_demux16_1to4_buf.sv
// Directed self-checking bench for demux16_1to4_buf; counter expectations follow DEMUX16_CNT_EN.
module tb_demux16_1to4_buf;

    localparam int unsigned CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic [15:0]      D_IN;
    logic [1:0]       SEL;
    logic             BCAST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [15:0]      D_OUT0, D_OUT1, D_OUT2, D_OUT3;
    logic [3:0]       OUT_VALID;
    logic [3:0]       OUT_READY;
    logic [CNT_W-1:0] CNT0, CNT1, CNT2, CNT3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    demux16_1to4_buf #(.CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .D_IN     (D_IN),
        .SEL      (SEL),
        .BCAST    (BCAST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .D_OUT0   (D_OUT0),
        .D_OUT1   (D_OUT1),
        .D_OUT2   (D_OUT2),
        .D_OUT3   (D_OUT3),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .CNT0     (CNT0),
        .CNT1     (CNT1),
        .CNT2     (CNT2),
        .CNT3     (CNT3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected counter value: live only when counters are built.
    function automatic logic [31:0] ec(input int unsigned v);
`ifdef DEMUX16_CNT_EN
        return 32'(v % 256);
`else
        return 32'(v - v);
`endif
    endfunction

    initial begin
        RST = 1'b1; IN_VALID = 1'b1; D_IN = 16'hFFFF; SEL = 2'd0; BCAST = 1'b0; OUT_READY = 4'b0000;
        tick();
        #1 chk("ready_in_reset", 32'(IN_READY), 32'd0);
        tick();
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        chk("rst_dout0", 32'(D_OUT0), 32'h0);
        chk("rst_dout1", 32'(D_OUT1), 32'h0);
        chk("rst_dout2", 32'(D_OUT2), 32'h0);
        chk("rst_dout3", 32'(D_OUT3), 32'h0);
        chk("rst_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_cnt0", 32'(CNT0), 32'h0);

        // Routing to channel 2 and back-pressure on a second word.
        SEL = 2'd2; D_IN = 16'hA5A5; IN_VALID = 1'b1;
        #1 chk("route_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("route_dout2", 32'(D_OUT2), 32'hA5A5);
        chk("route_valid", 32'(OUT_VALID), 32'h4);
        D_IN = 16'hBEEF;
        #1 chk("route_blocked", 32'(IN_READY), 32'd0);
        tick();
        chk("route_hold", 32'(D_OUT2), 32'hA5A5);
        OUT_READY = 4'b0100;
        #1 chk("route_unblock", 32'(IN_READY), 32'd1);
        tick();
        chk("route_reload", 32'(D_OUT2), 32'hBEEF);
        chk("route_reload_v", 32'(OUT_VALID), 32'h4);
        IN_VALID = 1'b0;
        tick();
        chk("route_drained", 32'(OUT_VALID), 32'h0);
        OUT_READY = 4'b0000;

        // Streaming eight words through channel 1 with no bubbles.
        SEL = 2'd1; OUT_READY = 4'b0010; IN_VALID = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            D_IN = 16'(i);
            #1 chk("stream_ready", 32'(IN_READY), 32'd1);
            tick();
            chk("stream_dout1", 32'(D_OUT1), 32'(i));
            chk("stream_valid", 32'(OUT_VALID), 32'h2);
        end
        IN_VALID = 1'b0;
        tick();
        chk("stream_done_v", 32'(OUT_VALID), 32'h0);
        chk("stream_cnt1", 32'(CNT1), ec(8));
        OUT_READY = 4'b0000;

        // Isolation: stalled channel 3 does not block channel 0.
        SEL = 2'd3; D_IN = 16'h3333; IN_VALID = 1'b1;
        tick();
        SEL = 2'd0; D_IN = 16'h1234;
        #1 chk("iso_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("iso_dout0", 32'(D_OUT0), 32'h1234);
        chk("iso_dout3", 32'(D_OUT3), 32'h3333);
        chk("iso_valid", 32'(OUT_VALID), 32'h9);

        // Drain 0 and 3 while filling channel 1.
        OUT_READY = 4'b1001; SEL = 2'd1; D_IN = 16'h1111;
        tick();
        chk("pre_bc_valid", 32'(OUT_VALID), 32'h2);
        chk("pre_bc_cnt0", 32'(CNT0), ec(1));
        chk("pre_bc_cnt3", 32'(CNT3), ec(1));

        // Broadcast waits until every slot is free, then writes all four.
        OUT_READY = 4'b0000; BCAST = 1'b1; D_IN = 16'h0F0F;
        #1 chk("bc_blocked", 32'(IN_READY), 32'd0);
        tick();
        chk("bc_no_write_v", 32'(OUT_VALID), 32'h2);
        chk("bc_no_write_d0", 32'(D_OUT0), 32'h1234);
        chk("bc_no_write_d1", 32'(D_OUT1), 32'h1111);
        OUT_READY = 4'b0010;
        #1 chk("bc_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("bc_valid", 32'(OUT_VALID), 32'hF);
        chk("bc_d0", 32'(D_OUT0), 32'h0F0F);
        chk("bc_d1", 32'(D_OUT1), 32'h0F0F);
        chk("bc_d2", 32'(D_OUT2), 32'h0F0F);
        chk("bc_d3", 32'(D_OUT3), 32'h0F0F);
        chk("bc_cnt1", 32'(CNT1), ec(9));
        BCAST = 1'b0; OUT_READY = 4'b0000; IN_VALID = 1'b1; SEL = 2'd2; D_IN = 16'h7777;

        // Reset mid-transfer discards held words and ignores the presented input.
        RST = 1'b1;
        tick();
        chk("mrst_valid", 32'(OUT_VALID), 32'h0);
        chk("mrst_d2", 32'(D_OUT2), 32'h0);
        chk("mrst_cnt1", 32'(CNT1), 32'h0);
        RST = 1'b0; IN_VALID = 1'b0;
        tick();
        chk("mrst_idle_v", 32'(OUT_VALID), 32'h0);

        // Counter wrap: 256 deliveries on channel 0.
        SEL = 2'd0; OUT_READY = 4'b0001; IN_VALID = 1'b1;
        for (int i = 0; i < 256; i++) begin
            D_IN = 16'(i);
            tick();
        end
        chk("wrap_cnt0_255", 32'(CNT0), ec(255));
        IN_VALID = 1'b0;
        tick();
        chk("wrap_cnt0_0", 32'(CNT0), ec(256));
        chk("wrap_valid", 32'(OUT_VALID), 32'h0);
        chk("wrap_cnt2", 32'(CNT2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
